ti_packet_parser: RTL and testbench

TI_PACKET_PARSER -- requirements
Module: ti_packet_parser

---
 rtl/ti_packet_parser.sv | 150 +++++++++++++++
 tb/tb_ti_packet_parser.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ti_packet_parser.sv
// NoC packet parser: target, size, HEADER_SIZE service-header flits, then a payload stream.
// Optional macro TI_SERVICE_FILTER_EN drops packets whose service word is unknown and counts them.
module ti_packet_parser #(
    parameter int unsigned FLIT_SIZE   = 32,
    parameter int unsigned HEADER_SIZE = 13
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              rx_i,
    input  logic [FLIT_SIZE-1:0]              data_i,
    output logic                              credit_o,
    output logic                              hdr_valid_o,
    input  logic                              hdr_ack_i,
    output logic [HEADER_SIZE*FLIT_SIZE-1:0]  hdr_o,
    output logic [FLIT_SIZE-1:0]              service_o,
    output logic                              known_o,
    output logic                              payload_valid_o,
    output logic                              payload_last_o,
    output logic [FLIT_SIZE-1:0]              payload_data_o,
    input  logic                              payload_ready_i,
    output logic                              err_o
`ifdef TI_SERVICE_FILTER_EN
    ,
    output logic [15:0]                       drop_count_o
`endif
);

    localparam int unsigned IDX_W = (HEADER_SIZE > 1) ? $clog2(HEADER_SIZE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SIZE,
        S_HEADER,
        S_HDR_WAIT,
        S_PAYLOAD,
        S_DROP
    } state_t;

    state_t                                 state_q;
    logic [FLIT_SIZE-1:0]                   remaining_q;
    logic [IDX_W-1:0]                       hdr_idx_q;
    logic [HEADER_SIZE-1:0][FLIT_SIZE-1:0]  hdr_q;
    logic                                   err_q;
    logic                                   accept_c;

    function automatic logic is_known(input logic [FLIT_SIZE-1:0] w);
        case (w)
            FLIT_SIZE'(32'h00), FLIT_SIZE'(32'h01), FLIT_SIZE'(32'h10), FLIT_SIZE'(32'h26),
            FLIT_SIZE'(32'h31), FLIT_SIZE'(32'h34), FLIT_SIZE'(32'h40): return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Flow control and state-decoded outputs; all forced low while reset is held
    always_comb begin
        credit_o = 1'b0;
        if (!rst_i) begin
            case (state_q)
                S_HDR_WAIT: credit_o = 1'b0;
                S_PAYLOAD:  credit_o = payload_ready_i;
                default:    credit_o = 1'b1;
            endcase
        end
    end

    assign accept_c        = rx_i && credit_o;
    assign hdr_valid_o     = !rst_i && (state_q == S_HDR_WAIT);
    assign payload_valid_o = !rst_i && (state_q == S_PAYLOAD) && rx_i;
    assign payload_last_o  = !rst_i && (state_q == S_PAYLOAD) && (remaining_q == FLIT_SIZE'(1));
    assign payload_data_o  = data_i;
    assign err_o           = err_q && !rst_i;
    assign hdr_o           = hdr_q;
    assign service_o       = hdr_q[0];
    assign known_o         = is_known(service_o);

`ifdef TI_SERVICE_FILTER_EN
    logic [15:0]          drop_count_q;
    logic [FLIT_SIZE-1:0] last_svc_c;

    // Word 0 may still be on data_i when the header is a single flit
    assign last_svc_c   = (hdr_idx_q == '0) ? data_i : hdr_q[0];
    assign drop_count_o = drop_count_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            hdr_idx_q    <= '0;
            hdr_q        <= '0;
            err_q        <= 1'b0;
`ifdef TI_SERVICE_FILTER_EN
            drop_count_q <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_c) state_q <= S_SIZE;
                end
                S_SIZE: begin
                    if (accept_c) begin
                        remaining_q <= data_i;
                        hdr_idx_q   <= '0;
                        if (data_i == '0) begin
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else if (data_i < FLIT_SIZE'(HEADER_SIZE)) begin
                            err_q   <= 1'b1;
                            state_q <= S_DROP;
                        end else begin
                            state_q <= S_HEADER;
                        end
                    end
                end
                S_HEADER: begin
                    if (accept_c) begin
                        hdr_q[hdr_idx_q] <= data_i;
                        remaining_q      <= remaining_q - FLIT_SIZE'(1);
                        hdr_idx_q        <= hdr_idx_q + IDX_W'(1);
                        if (hdr_idx_q == IDX_W'(HEADER_SIZE - 1)) begin
`ifdef TI_SERVICE_FILTER_EN
                            if (!is_known(last_svc_c)) begin
                                err_q   <= 1'b1;
                                state_q <= (remaining_q == FLIT_SIZE'(1)) ? S_IDLE : S_DROP;
                                if (drop_count_q != '1) drop_count_q <= drop_count_q + 16'd1;
                            end else begin
                                state_q <= S_HDR_WAIT;
                            end
`else
                            state_q <= S_HDR_WAIT;
`endif
                        end
                    end
                end
                S_HDR_WAIT: begin
                    if (hdr_ack_i) state_q <= (remaining_q != '0) ? S_PAYLOAD : S_IDLE;
                end
                S_PAYLOAD, S_DROP: begin
                    if (accept_c) begin
                        remaining_q <= remaining_q - FLIT_SIZE'(1);
                        if (remaining_q == FLIT_SIZE'(1)) state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ti_packet_parser.sv
// Self-checking bench for ti_packet_parser: directed packet table, reset sequences and random packets
// checked against a packet-level reference model (expected headers, payload beats and error counts).
module tb_ti_packet_parser;

    localparam int unsigned F = 32;
    localparam int unsigned H = 13;
    localparam int unsigned HW = H * F;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b0;
    logic [F-1:0]  data = '0;
    logic          credit;
    logic          hdr_valid;
    logic          ack = 1'b0;
    logic [HW-1:0] hdr;
    logic [F-1:0]  service;
    logic          known;
    logic          pvalid;
    logic          plast;
    logic [F-1:0]  pdata;
    logic          rdy = 1'b1;
    logic          err;
`ifdef TI_SERVICE_FILTER_EN
    logic [15:0]   drop_count;
`endif

    ti_packet_parser #(.FLIT_SIZE(F), .HEADER_SIZE(H)) dut (
        .clk_i(clk), .rst_i(rst), .rx_i(rx), .data_i(data), .credit_o(credit),
        .hdr_valid_o(hdr_valid), .hdr_ack_i(ack), .hdr_o(hdr), .service_o(service),
        .known_o(known), .payload_valid_o(pvalid), .payload_last_o(plast),
        .payload_data_o(pdata), .payload_ready_i(rdy), .err_o(err)
`ifdef TI_SERVICE_FILTER_EN
        , .drop_count_o(drop_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [F-1:0]  txq[$];
    logic [HW-1:0] exp_hdr_q[$];
    logic [F:0]    exp_beat_q[$];
    int            exp_err = 0;
    int            exp_drop = 0;

    // Observations
    int            err_seen = 0;
    int            hdr_seen = 0;
    int            beats_seen = 0;
    logic          hdr_prev = 1'b0;
    logic [HW-1:0] cur_hdr = '0;

    // Stimulus knobs
    int            rx_rand = 0;
    int            rdy_mode = 0;   // 0: always ready, 1: random, 2: alternating
    int            ack_cfg = 0;    // <0: random delay
    int            ack_wait = 0;

    typedef struct {
        int        size;
        logic [F-1:0] svc;
        int        ack_dly;
        int        exp_err;
        int        exp_hdr;
        int        exp_beats;
    } vec_t;

    function automatic logic is_known(input logic [F-1:0] w);
        return (w == 32'h00) || (w == 32'h01) || (w == 32'h10) || (w == 32'h26) ||
               (w == 32'h31) || (w == 32'h34) || (w == 32'h40);
    endfunction

    task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Packet-level model: what the parser must report for one packet
    task automatic add_pkt(input int size, input logic [F-1:0] svc);
        logic [HW-1:0] h;
        logic [F-1:0]  w;
        logic          deliver;
        txq.push_back(F'($urandom()));
        txq.push_back(F'(size));
        if (size == 0) begin
            exp_err++;
        end else if (size < int'(H)) begin
            exp_err++;
            repeat (size) txq.push_back(F'($urandom()));
        end else begin
            h = '0;
            for (int i = 0; i < int'(H); i++) begin
                w = (i == 0) ? svc : F'($urandom());
                h[i*F +: F] = w;
                txq.push_back(w);
            end
            deliver = 1'b1;
`ifdef TI_SERVICE_FILTER_EN
            deliver = is_known(svc);
`endif
            if (deliver) exp_hdr_q.push_back(h);
            else begin
                exp_err++;
                exp_drop++;
            end
            for (int i = 0; i < size - int'(H); i++) begin
                w = F'($urandom());
                txq.push_back(w);
                if (deliver) exp_beat_q.push_back({(i == size - int'(H) - 1), w});
            end
        end
    endtask

    task automatic monitor();
        logic [F:0] b;
        if (err) err_seen++;
        if (hdr_valid) begin
            if (!hdr_prev) begin
                hdr_seen++;
                if (exp_hdr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL hdr_unexpected actual=%0h required=none", service);
                    cur_hdr = hdr;
                end else begin
                    cur_hdr = exp_hdr_q.pop_front();
                end
            end
            chk("hdr_o", hdr, cur_hdr);
            chk("service_o", HW'(service), HW'(cur_hdr[F-1:0]));
            chk("known_o", HW'(known), HW'(is_known(cur_hdr[F-1:0])));
            chk("credit_in_wait", HW'(credit), '0);
            chk("pvalid_in_wait", HW'(pvalid), '0);
        end
        if (pvalid) begin
            chk("credit_follows_ready", HW'(credit), HW'(rdy));
            chk("pdata_zero_latency", HW'(pdata), HW'(data));
            if (rdy) begin
                beats_seen++;
                if (exp_beat_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat_unexpected actual=%0h required=none", pdata);
                end else begin
                    b = exp_beat_q.pop_front();
                    chk("beat_data", HW'(pdata), HW'(b[F-1:0]));
                    chk("beat_last", HW'(plast), HW'(b[F]));
                end
            end
        end
        hdr_prev = hdr_valid;
    endtask

    // One clock cycle, entered and left at posedge+1
    task automatic step();
        rx   = (txq.size() > 0) && ((rx_rand == 0) || ($urandom_range(0, 3) != 0));
        data = (txq.size() > 0) ? txq[0] : F'($urandom());
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = ($urandom_range(0, 2) != 0);
            default: rdy = ~rdy;
        endcase
        if (hdr_valid) begin
            ack = (ack_wait == 0);
            if (ack_wait > 0) ack_wait--;
        end else begin
            ack = 1'b0;
            ack_wait = (ack_cfg < 0) ? $urandom_range(0, 3) : ack_cfg;
        end
        #4;
        monitor();
        if (rx && credit) void'(txq.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int budget);
        int n = 0;
        while ((txq.size() > 0 || exp_hdr_q.size() > 0 || exp_beat_q.size() > 0 || hdr_valid)
               && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL timeout actual=%0d required<%0d cycles", n, budget);
            txq.delete();
            exp_hdr_q.delete();
            exp_beat_q.delete();
        end
        repeat (3) step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_credit"}, HW'(credit), '0);
        chk({tag, "_hdr_valid"}, HW'(hdr_valid), '0);
        chk({tag, "_pvalid"}, HW'(pvalid), '0);
        chk({tag, "_plast"}, HW'(plast), '0);
        chk({tag, "_err"}, HW'(err), '0);
    endtask

    vec_t vecs[8];

    initial begin
        int e0, h0, b0;
        int sz;
        logic [F-1:0] svc;
        logic [F-1:0] known_list[7];

        known_list = '{32'h00, 32'h01, 32'h10, 32'h26, 32'h31, 32'h34, 32'h40};
        vecs[0] = '{15, 32'h40, 0, 0, 1, 2};
        vecs[1] = '{13, 32'h01, 5, 0, 1, 0};
        vecs[2] = '{5,  32'h40, 0, 1, 0, 0};
        vecs[3] = '{0,  32'h40, 0, 1, 0, 0};
        vecs[4] = '{14, 32'h26, 1, 0, 1, 1};
`ifdef TI_SERVICE_FILTER_EN
        vecs[5] = '{16, 32'h99, 0, 1, 0, 0};
`else
        vecs[5] = '{16, 32'h99, 0, 0, 1, 3};
`endif
        vecs[6] = '{12, 32'h10, 0, 1, 0, 0};
        vecs[7] = '{13, 32'h00, 2, 0, 1, 0};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #4;
        chk_reset_outputs("reset");
        chk("reset_hdr_o", hdr, '0);
        #2;
        rst = 1'b0;
        #3;
        chk("credit_after_reset", HW'(credit), HW'(1'b1));
        @(posedge clk);
        #1;

        // Directed packet table
        for (int i = 0; i < 8; i++) begin
            e0 = err_seen;
            h0 = hdr_seen;
            b0 = beats_seen;
            ack_cfg = vecs[i].ack_dly;
            add_pkt(vecs[i].size, vecs[i].svc);
            run(400);
            chk($sformatf("vec%0d_err", i), HW'(err_seen - e0), HW'(vecs[i].exp_err));
            chk($sformatf("vec%0d_hdr", i), HW'(hdr_seen - h0), HW'(vecs[i].exp_hdr));
            chk($sformatf("vec%0d_beats", i), HW'(beats_seen - b0), HW'(vecs[i].exp_beats));
`ifdef TI_SERVICE_FILTER_EN
            chk($sformatf("vec%0d_drop_count", i), HW'(drop_count), HW'(exp_drop));
`endif
        end

        // Ready alternating during a 3-flit payload
        b0 = beats_seen;
        rdy_mode = 2;
        ack_cfg = 0;
        add_pkt(16, 32'h31);
        run(400);
        chk("toggle_beats", HW'(beats_seen - b0), HW'(3));
        rdy_mode = 0;

        // Reset in the middle of the header
        txq.push_back(32'hAAAA);
        txq.push_back(32'd15);
        repeat (5) txq.push_back(F'($urandom()));
        for (int n = 0; n < 40 && txq.size() > 0; n++) step();
        rx = 1'b0;
        rst = 1'b1;
        #4;
        chk_reset_outputs("midrst0");
        @(posedge clk);
        #5;
        chk_reset_outputs("midrst1");
        chk("midrst_hdr_cleared", hdr, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hdr_prev = 1'b0;
        txq.delete();
        e0 = err_seen;
        h0 = hdr_seen;
        b0 = beats_seen;
        add_pkt(15, 32'h34);
        run(400);
        chk("after_rst_err", HW'(err_seen - e0), '0);
        chk("after_rst_hdr", HW'(hdr_seen - h0), HW'(1));
        chk("after_rst_beats", HW'(beats_seen - b0), HW'(2));

        // Random packets against the model
        rx_rand = 1;
        rdy_mode = 1;
        ack_cfg = -1;
        for (int p = 0; p < 40; p++) begin
            case ($urandom_range(0, 9))
                0:       sz = 0;
                1, 2:    sz = $urandom_range(1, 12);
                default: sz = $urandom_range(13, 20);
            endcase
            svc = ($urandom_range(0, 3) == 0) ? F'($urandom()) : known_list[$urandom_range(0, 6)];
            add_pkt(sz, svc);
        end
        run(20000);
        chk("total_err_pulses", HW'(err_seen), HW'(exp_err));
`ifdef TI_SERVICE_FILTER_EN
        chk("final_drop_count", HW'(drop_count), HW'(exp_drop));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
